// File: rtl/aou_seq_pkg.sv
// Shared types and constants for the AOU round-robin sequencer.
// Optional divide-by-zero bypass is selected with AOU_SEQ_DIV0_CHECK_EN.
package aou_seq_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_MUL = 2'b10,
      OP_DIV = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam logic [3:0] AOU_NOP = 4'b0000;
   localparam logic [3:0] AOU_ADD = 4'b0110;
   localparam logic [3:0] AOU_SUB = 4'b0111;
   localparam logic [3:0] AOU_MUL = 4'b1000;
   localparam logic [3:0] AOU_DIV = 4'b1001;

   localparam logic [7:0] DIV0_RESULT = 8'hFF;

   typedef struct packed {
      op_e        op;
      logic [3:0] a;
      logic [3:0] b;
   } cmd_t;

   function automatic logic [3:0] aou_code(op_e op);
      logic [3:0] c;
      unique case (1'b1)
         op == OP_ADD: c = AOU_ADD;
         op == OP_SUB: c = AOU_SUB;
         op == OP_MUL: c = AOU_MUL;
         op == OP_DIV: c = AOU_DIV;
         default:      c = AOU_NOP;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/aou_sequencer_arb.sv
// Combinational round-robin arbiter: search starts one past last_grant.
// Produces a one-hot grant, its binary index and an any-valid flag.
module aou_rr_arbiter #(
   parameter int NREQ = 2
) (
   input  logic [NREQ-1:0]         valid,
   input  logic [$clog2(NREQ)-1:0] last_grant,
   output logic [NREQ-1:0]         grant,
   output logic [$clog2(NREQ)-1:0] idx,
   output logic                    any_valid
);

   localparam int IW = $clog2(NREQ);

   logic found;
   int   j;

   always_comb begin
      grant     = '0;
      idx       = '0;
      found     = 1'b0;
      j         = 0;
      any_valid = |valid;
      for (int k = 1; k <= NREQ; k++) begin
         j = (int'(last_grant) + k) % NREQ;
         if (!found && valid[j]) begin
            found    = 1'b1;
            grant[j] = 1'b1;
            idx      = IW'(j);
         end
      end
   end

endmodule

// File: rtl/aou_sequencer.sv
// Round-robin sequencer owning the AOU input pins for NREQ requesters.
// Define AOU_SEQ_DIV0_CHECK_EN to answer DIV by zero without the AOU.
module aou_sequencer
   import aou_seq_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int LAT  = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [2*NREQ-1:0]       req_op,
   input  logic [4*NREQ-1:0]       req_a,
   input  logic [4*NREQ-1:0]       req_b,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [$clog2(NREQ)-1:0] rsp_id,
   output logic [7:0]              rsp_y,
   output logic                    rsp_v,
   output logic                    rsp_div0,
   output logic [3:0]              aou_op,
   output logic [3:0]              aou_a,
   output logic [3:0]              aou_b,
   input  logic [7:0]              aou_y,
   input  logic                    aou_v,
   output logic                    busy
);

   localparam int IW = $clog2(NREQ);
   localparam int CW = 3;

`ifdef AOU_SEQ_DIV0_CHECK_EN
   localparam bit DIV0_EN = 1'b1;
`else
   localparam bit DIV0_EN = 1'b0;
`endif

   state_e          state_q, state_d;
   cmd_t            cmd_q, sel_cmd;
   logic [IW-1:0]   id_q, last_q, win_idx;
   logic [NREQ-1:0] grant;
   logic            any_valid;
   logic [CW-1:0]   cnt_q;
   logic [7:0]      y_q;
   logic            v_q, div0_q;
   logic            accept, sel_div0, done;

   aou_rr_arbiter #(.NREQ(NREQ)) u_arb (
      .valid      (req_valid),
      .last_grant (last_q),
      .grant      (grant),
      .idx        (win_idx),
      .any_valid  (any_valid)
   );

   always_comb begin
      sel_cmd.op = op_e'(req_op[2*win_idx +: 2]);
      sel_cmd.a  = req_a[4*win_idx +: 4];
      sel_cmd.b  = req_b[4*win_idx +: 4];
   end

   assign accept   = (state_q == IDLE) && any_valid;
   assign sel_div0 = DIV0_EN && (sel_cmd.op == OP_DIV)
                     && (sel_cmd.b == 4'd0);
   assign done     = (state_q == EXEC) && (cnt_q == '0);

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (any_valid) state_d = sel_div0 ? RESP : EXEC;
         EXEC: if (cnt_q == '0) state_d = RESP;
         RESP: if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cmd_q  <= '0;
         id_q   <= '0;
         last_q <= IW'(NREQ - 1);
         cnt_q  <= '0;
         y_q    <= '0;
         v_q    <= 1'b0;
         div0_q <= 1'b0;
      end else begin
         if (accept) begin
            cmd_q  <= sel_cmd;
            id_q   <= win_idx;
            last_q <= win_idx;
            cnt_q  <= CW'(LAT);
            if (sel_div0) begin
               y_q    <= DIV0_RESULT;
               v_q    <= 1'b0;
               div0_q <= 1'b1;
            end
         end
         if (state_q == EXEC && cnt_q != '0)
            cnt_q <= cnt_q - 1'b1;
         // overflow is only meaningful for ADD/SUB
         if (done) begin
            y_q    <= aou_y;
            v_q    <= aou_v && (cmd_q.op == OP_ADD
                                || cmd_q.op == OP_SUB);
            div0_q <= 1'b0;
         end
      end
   end

   always_comb begin
      req_ready = '0;
      aou_op    = AOU_NOP;
      aou_a     = '0;
      aou_b     = '0;
      if (state_q == IDLE) req_ready = grant;
      if (state_q == EXEC) begin
         aou_op = aou_code(cmd_q.op);
         aou_a  = cmd_q.a;
         aou_b  = cmd_q.b;
      end
      rsp_valid = (state_q == RESP);
      busy      = (state_q != IDLE);
   end

   assign rsp_id   = id_q;
   assign rsp_y    = y_q;
   assign rsp_v    = v_q;
   assign rsp_div0 = DIV0_EN ? div0_q : 1'b0;

endmodule

// File: doc/aou_sequencer.md
Name: aou_sequencer

Overview:
- Round-robin scheduler sharing one AOU arithmetic unit (add/sub/mul/div, 4-bit operands, 8-bit result, registered output) between NREQ requesters.
- Accepts one command at a time over a valid/ready handshake and drives the AOU opcode/operands.
- Waits the AOU latency, captures the result and overflow flag, and returns them tagged with the requester id over a response handshake.
- Sits between the requesting blocks and the AOU instance; the only owner of the AOU input pins.

Parameters:
NREQ, 2, number of requesters (2..8)
LAT, 1, cycles from AOU input sampling edge to valid aou_y/aou_v (1..7)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  NREQ  per-requester command valid
req_ready  out  NREQ  per-requester accept, one-hot or zero
req_op  in  2*NREQ  per-requester op: 00 ADD, 01 SUB, 10 MUL, 11 DIV
req_a  in  4*NREQ  per-requester operand A
req_b  in  4*NREQ  per-requester operand B
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_id  out  $clog2(NREQ)  index of the requester owning the response
rsp_y  out  8  result
rsp_v  out  1  signed overflow (ADD/SUB only)
rsp_div0  out  1  divide-by-zero flag (see Optional Feature)
aou_op  out  4  AOU opcode
aou_a  out  4  AOU operand A
aou_b  out  4  AOU operand B
aou_y  in  8  AOU result
aou_v  in  1  AOU overflow
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset is synchronous and active-low, taking effect on the clk edge where rst_n=0, including mid-operation.
  - State goes to IDLE.
  - rsp_valid, rsp_y, rsp_v, rsp_div0, rsp_id, aou_a, aou_b and busy are all 0.
  - aou_op is 4'b0000, a code the AOU ignores.
  - last_grant is NREQ-1, so requester 0 wins first.
  - An in-flight command is dropped silently.
- States: IDLE, EXEC, RESP.
- IDLE:
  - When any req_valid bit is high, the winner is the first valid index searched from last_grant+1, wrapping modulo NREQ.
  - req_ready[winner]=1 combinationally in the same cycle. All other ready bits stay 0.
  - On that edge, capture op, a, b and id into internal registers, load cnt=LAT, update last_grant=winner, go to EXEC.
- req_ready is 0 in every state except IDLE.
- EXEC:
  - aou_op/aou_a/aou_b are driven from the captured registers and held stable for the whole state.
  - Op mapping: ADD→0110, SUB→0111, MUL→1000, DIV→1001.
  - If cnt≠0, decrement cnt. If cnt==0, capture aou_y into rsp_y, capture rsp_v=aou_v for ADD/SUB or 0 for MUL/DIV, and go to RESP.
  - aou_op returns to 0000 on leaving EXEC.
- RESP:
  - rsp_valid=1. rsp_id/rsp_y/rsp_v/rsp_div0 stay stable until the rsp_valid&rsp_ready edge.
  - On that edge go to IDLE, and rsp_valid drops the next cycle.
  - No new request is accepted in the cycle of the handshake.
- Latency with LAT=1:
  - Accept edge at cycle 0, EXEC for cycles 1–2, rsp_valid first high in cycle 3.
  - With rsp_ready held high, a new accept is possible in cycle 4.
- Requesters must hold req_* stable while req_valid=1 and not yet accepted.
- Zero requests leave the block in IDLE, with aou_op=0000.

Optional Feature:
- Macro: AOU_SEQ_DIV0_CHECK_EN.
- With the macro defined:
  - A DIV with b==0 skips EXEC and goes from the accept edge straight to RESP.
  - rsp_y=8'hFF, rsp_v=0, rsp_div0=1, and aou_op stays 0000.
  - rsp_div0=0 for all other commands.
- Without the macro: DIV by zero runs through the AOU like any other command, rsp_y is whatever the AOU returns, and rsp_div0 is tied 0.
- The port exists in both builds.

Decomposition:
- Package aou_seq_pkg holds:
  - the op_e enum (ADD, SUB, MUL, DIV);
  - the AOU opcode localparams 0110/0111/1000/1001 and the idle code 0000;
  - the state_e enum (IDLE, EXEC, RESP);
  - the DIV0_RESULT constant 8'hFF.
- One sub-module, aou_rr_arbiter, parameterised by NREQ:
  - inputs: valid vector and last_grant;
  - outputs: one-hot grant, binary index, any_valid;
  - purely combinational.

Test Plan:
- Single ADD, requester 0, a=7, b=1, rsp_ready=1 → rsp_y[3:0]=4'b1000, rsp_v=1, rsp_id=0, rsp_valid first high 3 cycles after accept, aou_op=0110 only during EXEC.
- MUL from requester 1, a=3, b=5 → rsp_y=8'h0F, rsp_v=0 even if aou_v is stale-high from a prior overflowing ADD.
- Requesters 0 and 1 both valid continuously → accept order 0,1,0,1; req_ready never two-hot; requester 1 alone → granted immediately.
- rsp_ready held low 5 cycles in RESP → rsp_* stable, req_ready all 0, busy=1; release → IDLE next cycle.
- rst_n=0 for one cycle during EXEC of a SUB → next cycle IDLE, all outputs 0, aou_op=0000, no response emitted; the next grant goes to requester 0.
- With AOU_SEQ_DIV0_CHECK_EN, DIV a=9, b=0 → rsp_y=8'hFF, rsp_div0=1, aou_op never leaves 0000. Without the macro → rsp_div0=0 and aou_op=1001 during EXEC.
